seq_packer_dbuf: RTL and testbench
==================================

// Module: seq_packer_dbuf
// PURPOSE
//  Next-generation sequence packer in the match engine. It gathers single LZ sequences
//  (ll/ml/offset plus eoj/overlap/delim side info) into packets of PKT_SIZE slots for the
//  downstream sequence encoder. Ping-pong double buffering lets one packet fill while the
//  previous one waits at the output, so a packet flush costs no input bubble.
//  Packets close when full, on eoj or delim, or on an optional idle timeout.
// PARAMETERS
//  PKT_SIZE        4    slots per packet, power of two, >=2 (matches `SEQ_PACKET_SIZE)
//  LL_W            `SEQ_LL_BITS      literal-length width
//  ML_W            `SEQ_ML_BITS      match-length / overlap width
//  OFF_W           `SEQ_OFFSET_BITS  offset width
//  TIMEOUT_CYCLES  64   idle cycles before a partial packet is force-closed (timeout build only)
// PORTS
//  clk        in   1               clock
//  rst_n      in   1               asynchronous active-low reset
//  i_valid    in   1               input sequence valid
//  i_ll       in   LL_W            literal length
//  i_ml       in   ML_W            match length
//  i_offset   in   OFF_W           match offset
//  i_eoj      in   1               last sequence of job
//  i_overlap_len in ML_W           overlap length carried with the sequence
//  i_delim    in   1               block delimiter
//  i_ready    out  1               fill buffer can accept
//  o_valid    out  1               packet available
//  o_mask     out  PKT_SIZE        slot-occupied bits, always contiguous from bit 0
//  o_count    out  $clog2(PKT_SIZE)+1  popcount of o_mask
//  o_ll/o_ml/o_offset out PKT_SIZE*W  slot i is bits [i*W +: W]
//  o_overlap  out  ML_W            overlap of the last accepted sequence in the packet
//  o_eoj, o_delim out 1            OR of eoj/delim over the packet's sequences
//  o_ready    in   1               downstream accepts packet
// BEHAVIOUR
//  - Reset (async, rst_n=0): both buffers empty, wr_sel=rd_sel=0, idx=0, timer=0.
//    All outputs are 0. i_ready is 0 during reset and goes to 1 on the first clock after release.
//  - Two buffers B0/B1, each with a full flag. Input uses handshake fire_in = i_valid & i_ready.
//    i_ready = !full[wr_sel]. The output is a view of B[rd_sel]: o_valid = full[rd_sel].
//  - When fire_in occurs, write slot idx of B[wr_sel] and set its mask bit.
//    Overlap, eoj and delim are latched from that sequence.
//  - Close condition: idx==PKT_SIZE-1 | i_eoj | i_delim (on fire_in), or timeout.
//    On close: set full[wr_sel], toggle wr_sel, reset idx to 0.
//  - Drain: when o_valid & o_ready, clear full[rd_sel] and its mask/flags (payload is don't-care
//    but zeroed), then toggle rd_sel. o_* is held stable while o_valid & !o_ready.
//  - A close and a drain in the same cycle are legal. They always hit different buffers, except
//    when both buffers are full, and in that case no close can occur.
//  - Latency: the closing sequence is accepted in cycle t, and o_valid=1 in cycle t+1.
//    Sustained throughput is 1 seq/cycle with o_ready=1. With o_ready=0 held, at most
//    2*PKT_SIZE sequences are accepted before i_ready drops.
//  - Empty packets are never emitted. Buffer index arithmetic is 1 bit and wraps naturally.
//    idx is $clog2(PKT_SIZE) bits.
// CONFIGURATION
//  SEQ_PACKER_TIMEOUT_EN defined:
//    - An idle counter counts cycles with no fire_in while the fill buffer has at least 1 entry.
//    - When it reaches TIMEOUT_CYCLES, the partial packet closes, provided the other buffer is
//      not full; otherwise the counter saturates and the close happens once it is free.
//    - Any fire_in resets the counter to 0.
//  SEQ_PACKER_TIMEOUT_EN undefined: no counter logic exists, and partial packets close only on
//    eoj or delim.
// STRUCTURE
//  - Package seq_packer_pkg holds:
//      - typedef seq_t {ll, ml, offset, overlap, eoj, delim};
//      - typedef pkt_t {mask, seq_t slot[PKT_SIZE]};
//      - localparams IDX_W and CNT_W.
//  - Sub-module seq_pkt_buf (one packet buffer: slot write, clear, full flag), instantiated twice.
//    The top level holds wr_sel, rd_sel, idx, timer and the output mux.
// TESTING (PKT_SIZE=4)
//  1. 8 back-to-back seqs, o_ready=1 -> two packets, mask 4'b1111; i_ready never drops.
//  2. 2 seqs, then a 3rd with eoj=1, overlap=5 -> mask 4'b0111, count 3, o_eoj=1, o_overlap=5,
//     o_valid in the cycle after the 3rd.
//  3. o_ready=0, stream continuously -> exactly 8 accepted, then i_ready=0. Release o_ready ->
//     packets drain in order with payload intact.
//  4. Single seq with delim=1 -> mask 4'b0001, o_delim=1, next packet starts at slot 0.
//  5. Timeout build: 1 seq, then idle -> o_valid asserts TIMEOUT_CYCLES+1 cycles after
//     acceptance, mask 4'b0001. Non-timeout build: no o_valid after 1000 idle cycles.
//  6. rst_n pulled low mid-packet with o_valid=1 -> o_valid/o_mask go to 0 with no clock edge.
//     After release, the first seq lands in slot 0.

Source files
------------

// File: rtl/seq_packer_pkg.sv
// Shared types and widths for the double-buffered sequence packer.
// Optional idle-timeout close is enabled by defining SEQ_PACKER_TIMEOUT_EN.
package seq_packer_pkg;

  localparam int unsigned PKT_SIZE       = 4;
  localparam int unsigned LL_W           = 16;
  localparam int unsigned ML_W           = 16;
  localparam int unsigned OFF_W          = 17;

  localparam int unsigned TIMEOUT_CYCLES = 64;
  localparam int unsigned IDX_W          = $clog2(PKT_SIZE);
  localparam int unsigned CNT_W          = $clog2(PKT_SIZE) + 1;
  localparam int unsigned TMR_W          = $clog2(TIMEOUT_CYCLES + 1);

  typedef struct packed {
    logic [LL_W-1:0]  ll;
    logic [ML_W-1:0]  ml;
    logic [OFF_W-1:0] offset;
    logic [ML_W-1:0]  overlap;
    logic             eoj;
    logic             delim;
  } seq_t;

  typedef struct packed {
    logic [PKT_SIZE-1:0]   mask;
    seq_t [PKT_SIZE-1:0]   slot;
  } pkt_t;

  // Number of occupied slots in a packet
  function automatic logic [CNT_W-1:0] mask_count(input logic [PKT_SIZE-1:0] mask);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < PKT_SIZE; i++) n = n + CNT_W'(mask[i]);
    return n;
  endfunction

endpackage

// File: rtl/seq_packer_dbuf_if.sv
// Sequence-in / packet-out bus of the sequence packer.
interface seq_packer_dbuf_if;
  import seq_packer_pkg::*;

  logic                      i_valid;
  logic [LL_W-1:0]           i_ll;
  logic [ML_W-1:0]           i_ml;
  logic [OFF_W-1:0]          i_offset;
  logic                      i_eoj;
  logic [ML_W-1:0]           i_overlap_len;
  logic                      i_delim;
  logic                      i_ready;

  logic                      o_valid;
  logic [PKT_SIZE-1:0]       o_mask;
  logic [CNT_W-1:0]          o_count;
  logic [PKT_SIZE*LL_W-1:0]  o_ll;
  logic [PKT_SIZE*ML_W-1:0]  o_ml;
  logic [PKT_SIZE*OFF_W-1:0] o_offset;
  logic [ML_W-1:0]           o_overlap;
  logic                      o_eoj;
  logic                      o_delim;
  logic                      o_ready;

  modport master (
    output i_valid, i_ll, i_ml, i_offset, i_eoj, i_overlap_len, i_delim, o_ready,
    input  i_ready, o_valid, o_mask, o_count, o_ll, o_ml, o_offset, o_overlap, o_eoj, o_delim
  );

  modport slave (
    input  i_valid, i_ll, i_ml, i_offset, i_eoj, i_overlap_len, i_delim, o_ready,
    output i_ready, o_valid, o_mask, o_count, o_ll, o_ml, o_offset, o_overlap, o_eoj, o_delim
  );
endinterface

// File: rtl/seq_pkt_buf.sv
// One packet buffer: slot write with mask tracking, close (full) and drain clear.
module seq_pkt_buf
  import seq_packer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr,
  input  logic [IDX_W-1:0] i_idx,
  input  seq_t             i_seq,
  input  logic             i_close,
  input  logic             i_clr,
  output pkt_t             o_pkt,
  output logic             o_full
);

  pkt_t r_pkt;
  logic r_full;

  // Clear wins; write and clear never target the same buffer in one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt  <= '0;
      r_full <= 1'b0;
    end else if (i_clr) begin
      r_pkt  <= '0;
      r_full <= 1'b0;
    end else begin
      if (i_wr) begin
        r_pkt.slot[i_idx] <= i_seq;
        r_pkt.mask[i_idx] <= 1'b1;
      end
      if (i_close) r_full <= 1'b1;
    end
  end

  assign o_pkt  = r_pkt;
  assign o_full = r_full;

endmodule

// File: rtl/seq_packer_dbuf.sv
// Ping-pong sequence packer: fills one packet buffer while the other waits at the output.
// Define SEQ_PACKER_TIMEOUT_EN to force-close idle partial packets after TIMEOUT_CYCLES.
module seq_packer_dbuf
  import seq_packer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  seq_packer_dbuf_if.slave bus
);

  logic                      r_init;
  logic                      r_wr_sel;
  logic                      r_rd_sel;
  logic [IDX_W-1:0]          r_idx;

  logic [1:0]                w_full;
  pkt_t                      w_pkt [2];
  pkt_t                      w_rd_pkt;
  seq_t                      w_in_seq;
  logic                      w_fire;
  logic                      w_drain;
  logic                      w_close;
  logic                      w_to_close;
  logic [CNT_W-1:0]          w_cnt;
  logic [IDX_W-1:0]          w_last;
  logic [PKT_SIZE*LL_W-1:0]  w_ll;
  logic [PKT_SIZE*ML_W-1:0]  w_ml;
  logic [PKT_SIZE*OFF_W-1:0] w_off;
  logic                      w_eoj;
  logic                      w_delim;

  assign bus.i_ready = r_init & ~w_full[r_wr_sel];
  assign w_fire      = bus.i_valid & bus.i_ready;
  assign w_drain     = bus.o_valid & bus.o_ready;
  assign w_close     = (w_fire & ((r_idx == IDX_W'(PKT_SIZE - 1)) | bus.i_eoj | bus.i_delim))
                     | w_to_close;

  assign w_in_seq = '{ll: bus.i_ll, ml: bus.i_ml, offset: bus.i_offset,
                      overlap: bus.i_overlap_len, eoj: bus.i_eoj, delim: bus.i_delim};

  for (genvar b = 0; b < 2; b++) begin : g_buf
    seq_pkt_buf u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_wr    (w_fire  & (r_wr_sel == 1'(b))),
      .i_idx   (r_idx),
      .i_seq   (w_in_seq),
      .i_close (w_close & (r_wr_sel == 1'(b))),
      .i_clr   (w_drain & (r_rd_sel == 1'(b))),
      .o_pkt   (w_pkt[b]),
      .o_full  (w_full[b])
    );
  end

  // Buffer selection and fill index; r_init holds i_ready low until the first clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init   <= 1'b0;
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
      r_idx    <= '0;
    end else begin
      r_init <= 1'b1;
      if (w_close) begin
        r_wr_sel <= ~r_wr_sel;
        r_idx    <= '0;
      end else if (w_fire) begin
        r_idx <= r_idx + IDX_W'(1);
      end
      if (w_drain) r_rd_sel <= ~r_rd_sel;
    end
  end

`ifdef SEQ_PACKER_TIMEOUT_EN
  logic [TMR_W-1:0] r_timer;
  logic             w_fill_busy;

  assign w_fill_busy = ~w_full[r_wr_sel] & (w_pkt[r_wr_sel].mask != '0);
  // Close on the idle cycle that brings the count to TIMEOUT_CYCLES, once the other buffer is free
  assign w_to_close  = w_fill_busy & ~w_fire & ~w_full[~r_wr_sel]
                     & (r_timer >= TMR_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (w_fire || w_to_close) begin
      r_timer <= '0;
    end else if (w_fill_busy && (r_timer < TMR_W'(TIMEOUT_CYCLES))) begin
      r_timer <= r_timer + TMR_W'(1);
    end
  end
`else
  assign w_to_close = 1'b0;
`endif

  assign w_rd_pkt = w_pkt[r_rd_sel];
  assign w_cnt    = mask_count(w_rd_pkt.mask);
  assign w_last   = IDX_W'(w_cnt - CNT_W'(1));

  // Flatten the read buffer's slots onto the output bus
  always_comb begin
    w_ll    = '0;
    w_ml    = '0;
    w_off   = '0;
    w_eoj   = 1'b0;
    w_delim = 1'b0;
    for (int i = 0; i < PKT_SIZE; i++) begin
      w_ll[i*LL_W +: LL_W]   = w_rd_pkt.slot[i].ll;
      w_ml[i*ML_W +: ML_W]   = w_rd_pkt.slot[i].ml;
      w_off[i*OFF_W +: OFF_W] = w_rd_pkt.slot[i].offset;
      w_eoj   = w_eoj   | (w_rd_pkt.mask[i] & w_rd_pkt.slot[i].eoj);
      w_delim = w_delim | (w_rd_pkt.mask[i] & w_rd_pkt.slot[i].delim);
    end
  end

  assign bus.o_valid   = w_full[r_rd_sel];
  assign bus.o_mask    = w_rd_pkt.mask;
  assign bus.o_count   = w_cnt;
  assign bus.o_ll      = w_ll;
  assign bus.o_ml      = w_ml;
  assign bus.o_offset  = w_off;
  assign bus.o_overlap = w_rd_pkt.slot[w_last].overlap;
  assign bus.o_eoj     = w_eoj;
  assign bus.o_delim   = w_delim;

endmodule

// File: tb/tb_seq_packer_dbuf.sv
// Self-checking bench for seq_packer_dbuf: directed table, corner sequences, random vs. packet-queue model.
module tb_seq_packer_dbuf;
  import seq_packer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_packer_dbuf_if bus();
  seq_packer_dbuf dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_pass = 0;
  int n_chk  = 0;

  typedef struct {
    logic v; int ll; logic eoj; logic delim; int ovl; logic ordy;
    logic e_val; int e_mask; int e_cnt; logic e_eoj; logic e_delim; int e_ovl; int e_ll0;
  } vec_t;

  typedef struct packed {
    logic [CNT_W-1:0]     n;
    seq_t [PKT_SIZE-1:0]  s;
  } mpkt_t;

  mpkt_t pend_q[$];
  seq_t  cur_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mkv(logic v, int ll, logic eoj, logic delim, int ovl, logic ordy,
                               logic e_val, int e_mask, int e_cnt, logic e_eoj, logic e_delim,
                               int e_ovl, int e_ll0);
    vec_t r;
    r.v = v; r.ll = ll; r.eoj = eoj; r.delim = delim; r.ovl = ovl; r.ordy = ordy;
    r.e_val = e_val; r.e_mask = e_mask; r.e_cnt = e_cnt; r.e_eoj = e_eoj;
    r.e_delim = e_delim; r.e_ovl = e_ovl; r.e_ll0 = e_ll0;
    return r;
  endfunction

  function automatic seq_t mk_seq(int ll, int ml, int off, int ovl, logic eoj, logic delim);
    seq_t s;
    s.ll = LL_W'(ll); s.ml = ML_W'(ml); s.offset = OFF_W'(off);
    s.overlap = ML_W'(ovl); s.eoj = eoj; s.delim = delim;
    return s;
  endfunction

  task automatic drive(input logic v, input seq_t s, input logic ordy);
    bus.i_valid = v; bus.i_ll = s.ll; bus.i_ml = s.ml; bus.i_offset = s.offset;
    bus.i_overlap_len = s.overlap; bus.i_eoj = s.eoj; bus.i_delim = s.delim;
    bus.o_ready = ordy;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    drive(1'b0, '0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick;
    pend_q.delete();
    cur_q.delete();
  endtask

  task automatic model_close;
    mpkt_t m;
    m = '0;
    m.n = CNT_W'(cur_q.size());
    for (int i = 0; i < cur_q.size(); i++) m.s[i] = cur_q[i];
    pend_q.push_back(m);
    cur_q.delete();
  endtask

  task automatic check_head;
    mpkt_t                     m;
    logic [PKT_SIZE-1:0]       e_mask;
    logic [PKT_SIZE*LL_W-1:0]  e_ll;
    logic [PKT_SIZE*ML_W-1:0]  e_ml;
    logic [PKT_SIZE*OFF_W-1:0] e_off;
    logic                      e_eoj, e_delim;
    m = pend_q[0];
    e_mask = '0; e_ll = '0; e_ml = '0; e_off = '0; e_eoj = 1'b0; e_delim = 1'b0;
    for (int i = 0; i < PKT_SIZE; i++) begin
      if (i < int'(m.n)) begin
        e_mask[i] = 1'b1;
        e_ll[i*LL_W +: LL_W]    = m.s[i].ll;
        e_ml[i*ML_W +: ML_W]    = m.s[i].ml;
        e_off[i*OFF_W +: OFF_W] = m.s[i].offset;
        e_eoj   = e_eoj | m.s[i].eoj;
        e_delim = e_delim | m.s[i].delim;
      end
    end
    chk("rnd_mask",    128'(bus.o_mask),    128'(e_mask));
    chk("rnd_count",   128'(bus.o_count),   128'(m.n));
    chk("rnd_ll",      128'(bus.o_ll),      128'(e_ll));
    chk("rnd_ml",      128'(bus.o_ml),      128'(e_ml));
    chk("rnd_offset",  128'(bus.o_offset),  128'(e_off));
    chk("rnd_overlap", 128'(bus.o_overlap), 128'(m.s[int'(m.n) - 1].overlap));
    chk("rnd_eoj",     128'(bus.o_eoj),     128'(e_eoj));
    chk("rnd_delim",   128'(bus.o_delim),   128'(e_delim));
  endtask

  initial begin
    vec_t vt[10];
    int   acc, npk, seen, idle;

    vt[0] = mkv(1, 1, 0, 0, 2, 0,  0, 0, 0, 0, 0, 0, 0);
    vt[1] = mkv(1, 2, 0, 0, 3, 0,  0, 0, 0, 0, 0, 0, 0);
    vt[2] = mkv(1, 3, 1, 0, 5, 0,  1, 7, 3, 1, 0, 5, 1);
    vt[3] = mkv(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    vt[4] = mkv(1, 4, 0, 1, 7, 1,  1, 1, 1, 0, 1, 7, 4);
    vt[5] = mkv(1, 5, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0);
    vt[6] = mkv(1, 6, 0, 0, 2, 0,  0, 0, 0, 0, 0, 0, 0);
    vt[7] = mkv(1, 7, 0, 0, 3, 0,  0, 0, 0, 0, 0, 0, 0);
    vt[8] = mkv(1, 8, 0, 0, 9, 0,  1, 15, 4, 0, 0, 9, 5);
    vt[9] = mkv(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);

    // Reset state while rst_n is held low
    drive(1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 128'(bus.o_valid), 128'(0));
    chk("rst_ready", 128'(bus.i_ready), 128'(0));
    chk("rst_mask",  128'(bus.o_mask),  128'(0));
    chk("rst_count", 128'(bus.o_count), 128'(0));
    #1 rst_n = 1'b1;
    tick;
    chk("rst_ready_after", 128'(bus.i_ready), 128'(1));

    // Directed table: eoj packet, delim packet, full packet starting at slot 0
    for (int k = 0; k < 10; k++) begin
      drive(vt[k].v, mk_seq(vt[k].ll, vt[k].ll + 16, vt[k].ll + 32, vt[k].ovl, vt[k].eoj,
            vt[k].delim), vt[k].ordy);
      #1;
      chk("tbl_ready", 128'(bus.i_ready), 128'(1));
      tick;
      chk("tbl_valid", 128'(bus.o_valid), 128'(vt[k].e_val));
      if (vt[k].e_val) begin
        chk("tbl_mask",  128'(bus.o_mask),    128'(vt[k].e_mask));
        chk("tbl_count", 128'(bus.o_count),   128'(vt[k].e_cnt));
        chk("tbl_eoj",   128'(bus.o_eoj),     128'(vt[k].e_eoj));
        chk("tbl_delim", 128'(bus.o_delim),   128'(vt[k].e_delim));
        chk("tbl_ovl",   128'(bus.o_overlap), 128'(vt[k].e_ovl));
        chk("tbl_ll0",   128'(bus.o_ll[LL_W-1:0]), 128'(vt[k].e_ll0));
      end
    end

    // Back-to-back stream with o_ready=1: no input bubble, two full packets
    npk = 0;
    for (int k = 0; k < 10; k++) begin
      drive(k < 8, mk_seq(200 + k, k, k, k, 1'b0, 1'b0), 1'b1);
      #1;
      if (k < 8) chk("b2b_ready", 128'(bus.i_ready), 128'(1));
      if (bus.o_valid && bus.o_mask == 4'b1111) npk++;
      tick;
    end
    chk("b2b_packets", 128'(npk), 128'(2));

    // Stalled output: exactly two packets' worth accepted, then drained in order
    do_reset;
    acc = 0;
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, mk_seq(100 + acc, 0, 0, 0, 1'b0, 1'b0), 1'b0);
      #1;
      if (bus.i_ready) acc++;
      tick;
    end
    chk("stall_accepted", 128'(acc), 128'(2 * PKT_SIZE));
    chk("stall_ready", 128'(bus.i_ready), 128'(0));
    drive(1'b0, '0, 1'b1);
    for (int p = 0; p < 2; p++) begin
      chk("stall_valid", 128'(bus.o_valid), 128'(1));
      chk("stall_mask",  128'(bus.o_mask),  128'(4'b1111));
      for (int i = 0; i < PKT_SIZE; i++)
        chk("stall_ll", 128'(bus.o_ll[i*LL_W +: LL_W]), 128'(100 + p * PKT_SIZE + i));
      tick;
    end
    chk("stall_empty", 128'(bus.o_valid), 128'(0));

    // Idle partial packet: timeout close only in the timeout build
    do_reset;
    drive(1'b1, mk_seq(9, 1, 1, 3, 1'b0, 1'b0), 1'b1);
    tick;
    drive(1'b0, '0, 1'b0);
    seen = 0;
    for (int k = 1; k <= 1000; k++) begin
      if (bus.o_valid) begin
        seen = k;
        break;
      end
      tick;
    end
`ifdef SEQ_PACKER_TIMEOUT_EN
    chk("timeout_latency", 128'(seen), 128'(TIMEOUT_CYCLES + 1));
    chk("timeout_mask", 128'(bus.o_mask), 128'(4'b0001));
`else
    chk("no_timeout", 128'(seen), 128'(0));
`endif

    // Asynchronous reset with a packet pending at the output
    do_reset;
    drive(1'b1, mk_seq(5, 5, 5, 5, 1'b1, 1'b0), 1'b0);
    tick;
    drive(1'b0, '0, 1'b0);
    chk("areset_pre_valid", 128'(bus.o_valid), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("areset_valid", 128'(bus.o_valid), 128'(0));
    chk("areset_mask",  128'(bus.o_mask),  128'(0));
    chk("areset_ready", 128'(bus.i_ready), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_ready", 128'(bus.i_ready), 128'(0));
    tick;
    chk("release_ready_clk", 128'(bus.i_ready), 128'(1));
    drive(1'b1, mk_seq(51, 0, 0, 0, 1'b1, 1'b0), 1'b0);
    tick;
    drive(1'b0, '0, 1'b0);
    chk("release_valid", 128'(bus.o_valid), 128'(1));
    chk("release_mask",  128'(bus.o_mask),  128'(4'b0001));
    chk("release_ll0",   128'(bus.o_ll[LL_W-1:0]), 128'(51));

    // Random traffic against the packet-queue model
    do_reset;
    idle = 0;
    for (int c = 0; c < 3000; c++) begin
      logic v, ordy, fire, drain, do_close;
      int   pb;
      seq_t s;
      chk("rnd_valid", 128'(bus.o_valid), 128'(pend_q.size() > 0));
      if (pend_q.size() > 0) check_head;
      v    = ($urandom_range(0, 99) < 70);
      ordy = ($urandom_range(0, 99) < 60);
      s = mk_seq(int'($urandom), int'($urandom), int'($urandom), int'($urandom),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
      drive(v, s, ordy);
      #1;
      chk("rnd_ready", 128'(bus.i_ready), 128'(pend_q.size() < 2));
      pb    = pend_q.size();
      fire  = v && (pb < 2);
      drain = ordy && (pb > 0);
      if (drain) void'(pend_q.pop_front());
      do_close = 1'b0;
      if (fire) begin
        cur_q.push_back(s);
        if (cur_q.size() == PKT_SIZE || s.eoj || s.delim) do_close = 1'b1;
      end
`ifdef SEQ_PACKER_TIMEOUT_EN
      if (fire) idle = 0;
      else if (cur_q.size() > 0) begin
        if (idle < int'(TIMEOUT_CYCLES)) idle++;
        if (idle >= int'(TIMEOUT_CYCLES) && pb == 0) begin
          do_close = 1'b1;
          idle = 0;
        end
      end
`else
      idle = 0;
`endif
      if (do_close) model_close;
      tick;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
